// File: rtl/core_mem_s.sv
// core_mem_s: memory stage of the Selen pipeline. Issues L1D data-port
// requests, stalls until the access completes, aligns and extends load data,
// and registers the write-back result.
module core_mem_s (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enb,
  input  logic        mem_kill,
  input  logic [6:0]  mem_l1d_bus_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_w_data_in,
  input  logic [31:0] mem_alu_result_in,
  input  logic        mem_mux_alu_mem_in,
  input  logic        mem_we_reg_file_in,
  input  logic [2:0]  mem_wb_sx_op_in,
  output logic        l1d_req_val,
  output logic        l1d_req_we,
  output logic [31:0] l1d_req_addr,
  output logic [31:0] l1d_req_wdata,
  output logic [3:0]  l1d_req_be,
  input  logic        l1d_req_ack,
  input  logic        l1d_resp_val,
  input  logic [31:0] l1d_resp_data,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic [31:0] mem_wb_data_out_reg,
  output logic        mem_we_reg_file_out_reg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;

  logic        w_in_val, w_in_we, w_in_bad;
  logic [3:0]  w_in_be;
  logic [31:0] w_in_wdata;
  logic        w_take, w_busy;

  logic        r_we, r_mux, r_we_rf, r_killed;
  logic [31:0] r_addr, r_wdata, r_alu;
  logic [3:0]  r_be;
  logic [2:0]  r_sx_op;

  logic [31:0] w_sel_addr, w_sel_alu, w_ext, w_wb_data;
  logic [2:0]  w_sel_sx;
  logic        w_sel_mux, w_sel_we_rf;

  // Select the addressed byte/half of a read word and sign/zero-extend it.
  function automatic logic [31:0] f_extend(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  op);
    logic [31:0] sh_b, sh_h;
    logic [7:0]  b;
    logic [15:0] h;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (op)
      3'b001:  f_extend = {{24{b[7]}}, b};
      3'b010:  f_extend = {24'h000000, b};
      3'b011:  f_extend = {{16{h[15]}}, h};
      3'b100:  f_extend = {16'h0000, h};
      default: f_extend = word;
    endcase
  endfunction

  // Decode the incoming request: lane enables, replicated store data, legality.
  always_comb begin
    w_in_val   = mem_l1d_bus_in[6];
    w_in_we    = mem_l1d_bus_in[5];
    w_in_be    = 4'b0000;
    w_in_wdata = 32'h0000_0000;
    w_in_bad   = (mem_l1d_bus_in[2:0] != 3'b000);
    case (mem_l1d_bus_in[4:3])
      2'b00: begin
        w_in_be    = 4'b0001 << mem_addr_in[1:0];
        w_in_wdata = {4{mem_w_data_in[7:0]}};
      end
      2'b01: begin
        w_in_be    = mem_addr_in[1] ? 4'b1100 : 4'b0011;
        w_in_wdata = {2{mem_w_data_in[15:0]}};
        w_in_bad   = w_in_bad | mem_addr_in[0];
      end
      2'b10: begin
        w_in_be    = 4'b1111;
        w_in_wdata = mem_w_data_in;
        w_in_bad   = w_in_bad | (mem_addr_in[1:0] != 2'b00);
      end
      default: begin
        w_in_bad   = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and L1D request/stall/misalign outputs.
  always_comb begin
    w_state_nxt   = r_state;
    l1d_req_val   = 1'b0;
    l1d_req_we    = 1'b0;
    l1d_req_addr  = 32'h0000_0000;
    l1d_req_wdata = 32'h0000_0000;
    l1d_req_be    = 4'b0000;
    mem_stall     = 1'b0;
    mem_misalign  = 1'b0;
    w_take        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst && w_in_val && w_in_bad) begin
          mem_misalign = 1'b1;
        end else if (!rst && w_in_val) begin
          l1d_req_val   = 1'b1;
          l1d_req_we    = w_in_we;
          l1d_req_addr  = {mem_addr_in[31:2], 2'b00};
          l1d_req_wdata = w_in_wdata;
          l1d_req_be    = w_in_be;
          if (l1d_req_ack && w_in_we) begin
            w_state_nxt = IDLE;
          end else if (l1d_req_ack) begin
            w_state_nxt = WAIT_RESP;
            mem_stall   = 1'b1;
            w_take      = 1'b1;
          end else begin
            w_state_nxt = REQ;
            mem_stall   = 1'b1;
            w_take      = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        l1d_req_val   = 1'b1;
        l1d_req_we    = r_we;
        l1d_req_addr  = {r_addr[31:2], 2'b00};
        l1d_req_wdata = r_wdata;
        l1d_req_be    = r_be;
        if (l1d_req_ack && r_we) begin
          w_state_nxt = IDLE;
        end else if (l1d_req_ack) begin
          w_state_nxt = WAIT_RESP;
          mem_stall   = 1'b1;
        end else begin
          mem_stall   = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (l1d_resp_val) begin
          w_state_nxt = IDLE;
        end else begin
          mem_stall   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch the request and its write-back context when a transaction starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_be    <= 4'b0000;
      r_sx_op <= 3'b000;
      r_mux   <= 1'b0;
      r_we_rf <= 1'b0;
      r_alu   <= 32'h0000_0000;
    end else if (w_take) begin
      r_we    <= w_in_we;
      r_addr  <= mem_addr_in;
      r_wdata <= w_in_wdata;
      r_be    <= w_in_be;
      r_sx_op <= mem_wb_sx_op_in;
      r_mux   <= mem_mux_alu_mem_in;
      r_we_rf <= mem_we_reg_file_in;
      r_alu   <= mem_alu_result_in;
    end
  end

  // Remember a kill seen while a transaction is in flight so its result is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_killed <= 1'b0;
    end else if (w_take) begin
      r_killed <= mem_kill;
    end else if (r_state != IDLE) begin
      r_killed <= r_killed | mem_kill;
    end else begin
      r_killed <= 1'b0;
    end
  end

  assign w_busy      = (r_state != IDLE);
  assign w_sel_addr  = w_busy ? r_addr  : mem_addr_in;
  assign w_sel_sx    = w_busy ? r_sx_op : mem_wb_sx_op_in;
  assign w_sel_mux   = w_busy ? r_mux   : mem_mux_alu_mem_in;
  assign w_sel_we_rf = w_busy ? r_we_rf : mem_we_reg_file_in;
  assign w_sel_alu   = w_busy ? r_alu   : mem_alu_result_in;
  assign w_ext       = f_extend(l1d_resp_data, w_sel_addr[1:0], w_sel_sx);
  assign w_wb_data   = w_sel_mux ? w_ext : w_sel_alu;

  // Write-back output registers: kill wins, otherwise capture on enable without stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb_data_out_reg     <= 32'h0000_0000;
      mem_we_reg_file_out_reg <= 1'b0;
    end else if (mem_kill) begin
      mem_wb_data_out_reg     <= 32'h0000_0000;
      mem_we_reg_file_out_reg <= 1'b0;
    end else if (mem_enb && !mem_stall) begin
      if (mem_misalign || (w_busy && r_killed)) begin
        mem_wb_data_out_reg     <= 32'h0000_0000;
        mem_we_reg_file_out_reg <= 1'b0;
      end else begin
        mem_wb_data_out_reg     <= w_wb_data;
        mem_we_reg_file_out_reg <= w_sel_we_rf;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_s.sv
// tb_core_mem_s: randomized transaction-level bench for core_mem_s with a
// behavioural L1D responder and write-back result model.
module tb_core_mem_s;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enb, mem_kill;
  logic [6:0]  mem_l1d_bus_in;
  logic [31:0] mem_addr_in, mem_w_data_in, mem_alu_result_in;
  logic        mem_mux_alu_mem_in, mem_we_reg_file_in;
  logic [2:0]  mem_wb_sx_op_in;
  logic        l1d_req_val, l1d_req_we;
  logic [31:0] l1d_req_addr, l1d_req_wdata;
  logic [3:0]  l1d_req_be;
  logic        l1d_req_ack, l1d_resp_val;
  logic [31:0] l1d_resp_data;
  logic        mem_stall, mem_misalign;
  logic [31:0] mem_wb_data_out_reg;
  logic        mem_we_reg_file_out_reg;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_data;
  logic        exp_we;

  always #5 clk = ~clk;

  core_mem_s dut (
    .clk(clk), .rst(rst), .mem_enb(mem_enb), .mem_kill(mem_kill),
    .mem_l1d_bus_in(mem_l1d_bus_in), .mem_addr_in(mem_addr_in),
    .mem_w_data_in(mem_w_data_in), .mem_alu_result_in(mem_alu_result_in),
    .mem_mux_alu_mem_in(mem_mux_alu_mem_in), .mem_we_reg_file_in(mem_we_reg_file_in),
    .mem_wb_sx_op_in(mem_wb_sx_op_in), .l1d_req_val(l1d_req_val),
    .l1d_req_we(l1d_req_we), .l1d_req_addr(l1d_req_addr),
    .l1d_req_wdata(l1d_req_wdata), .l1d_req_be(l1d_req_be),
    .l1d_req_ack(l1d_req_ack), .l1d_resp_val(l1d_resp_val),
    .l1d_resp_data(l1d_resp_data), .mem_stall(mem_stall),
    .mem_misalign(mem_misalign), .mem_wb_data_out_reg(mem_wb_data_out_reg),
    .mem_we_reg_file_out_reg(mem_we_reg_file_out_reg)
  );

  // Count one comparison and report it if the observed value differs.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference load result: pick the lane arithmetically, extend by wrap-around subtraction.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] sx);
    logic [31:0] v;
    if (sx == 3'd1 || sx == 3'd2) begin
      v = (w >> (8 * (a % 4))) & 32'h0000_00FF;
      if (sx == 3'd1 && v >= 32'd128) v = v - 32'd256;
    end else if (sx == 3'd3 || sx == 3'd4) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
      if (sx == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // One complete stage transaction with the bench acting as the L1D.
  task automatic do_txn(input logic [6:0] bus, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] alu, input logic mux, input logic werf,
                        input logic [2:0] sx, input int ack_dly, input int resp_dly,
                        input logic [31:0] rdata, input logic enb, input int kill_k);
    logic        valid, wr, mis, go, killed;
    int          sz, comp, stalls;
    logic [31:0] ebe, ewd, res;
    valid = bus[6];
    wr    = bus[5];
    sz    = int'(bus[4:3]);
    mis   = valid && (sz == 3 || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0));
    go    = valid && !mis;
    comp  = !go ? 0 : (wr ? ack_dly : ack_dly + resp_dly);
    if (sz == 0) begin
      ebe = 32'd1 << (addr % 4);
      ewd = wd[7:0] * 32'h0101_0101;
    end else if (sz == 1) begin
      ebe = (addr % 4 >= 2) ? 32'hC : 32'h3;
      ewd = wd[15:0] * 32'h0001_0001;
    end else begin
      ebe = 32'hF;
      ewd = wd;
    end
    res    = mux ? ref_load(rdata, addr, sx) : alu;
    killed = 1'b0;
    stalls = 0;
    for (int k = 0; k <= comp; k++) begin
      @(negedge clk);
      if (k == 0) begin
        mem_l1d_bus_in = bus; mem_addr_in = addr; mem_w_data_in = wd;
        mem_alu_result_in = alu; mem_mux_alu_mem_in = mux;
        mem_we_reg_file_in = werf; mem_wb_sx_op_in = sx;
      end else begin
        mem_l1d_bus_in = 7'($urandom); mem_addr_in = $urandom; mem_w_data_in = $urandom;
        mem_alu_result_in = $urandom; mem_mux_alu_mem_in = 1'($urandom);
        mem_we_reg_file_in = 1'($urandom); mem_wb_sx_op_in = 3'($urandom);
      end
      mem_enb       = enb;
      mem_kill      = (k == kill_k);
      l1d_req_ack   = go && (k == ack_dly);
      l1d_resp_val  = go && !wr && (k == comp);
      l1d_resp_data = rdata;
      #1;
      chk("req_val", 32'(l1d_req_val), 32'(go && k <= ack_dly));
      if (go && k <= ack_dly) begin
        chk("req_we", 32'(l1d_req_we), 32'(wr));
        chk("req_addr", l1d_req_addr, addr & 32'hFFFF_FFFC);
        chk("req_wdata", l1d_req_wdata, ewd);
        chk("req_be", 32'(l1d_req_be), ebe);
      end
      chk("stall", 32'(mem_stall), 32'(k < comp));
      if (mem_stall) stalls++;
      chk("misalign", 32'(mem_misalign), 32'(mis && k == 0));
      @(posedge clk);
      #1;
      if (k == kill_k) begin
        exp_data = 32'h0; exp_we = 1'b0; killed = 1'b1;
      end else if (k == comp && enb) begin
        if (mis || killed) begin
          exp_data = 32'h0; exp_we = 1'b0;
        end else begin
          exp_data = res; exp_we = werf;
        end
      end
      chk("wb_data", mem_wb_data_out_reg, exp_data);
      chk("wb_we", 32'(mem_we_reg_file_out_reg), 32'(exp_we));
    end
    chk("stall_cycles", 32'(stalls), 32'(comp));
  endtask

  initial begin
    int          ack_d, resp_d, kk;
    logic [6:0]  bus;
    // Reset state, with a valid request presented on the inputs.
    rst = 1'b1; mem_enb = 1'b1; mem_kill = 1'b0;
    mem_l1d_bus_in = 7'b1010000; mem_addr_in = 32'h0000_0100; mem_w_data_in = 32'h0;
    mem_alu_result_in = 32'h0; mem_mux_alu_mem_in = 1'b0; mem_we_reg_file_in = 1'b0;
    mem_wb_sx_op_in = 3'b000; l1d_req_ack = 1'b0; l1d_resp_val = 1'b0; l1d_resp_data = 32'h0;
    exp_data = 32'h0; exp_we = 1'b0;
    #2;
    chk("rst_req_val", 32'(l1d_req_val), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_misalign", 32'(mem_misalign), 32'h0);
    chk("rst_be", 32'(l1d_req_be), 32'h0);
    chk("rst_wb_data", mem_wb_data_out_reg, 32'h0);
    chk("rst_wb_we", 32'(mem_we_reg_file_out_reg), 32'h0);
    @(negedge clk);
    mem_l1d_bus_in = 7'b0;
    rst = 1'b0;

    // Directed cases.
    do_txn(7'b1100000, 32'h0000_1003, 32'h0000_00A5, 32'h1111_1111, 1'b0, 1'b0, 3'd0, 2, 0, 32'h0, 1'b1, -1);
    do_txn(7'b1000000, 32'h0000_2001, 32'h0, 32'h0, 1'b1, 1'b1, 3'd1, 0, 3, 32'h0000_8000, 1'b1, -1);
    do_txn(7'b1000000, 32'h0000_2001, 32'h0, 32'h0, 1'b1, 1'b1, 3'd2, 0, 3, 32'h0000_8000, 1'b1, -1);
    do_txn(7'b1001000, 32'h0000_2002, 32'h0, 32'h0, 1'b1, 1'b1, 3'd3, 0, 1, 32'h8001_1234, 1'b1, -1);
    do_txn(7'b1010000, 32'h0000_2000, 32'h0, 32'h0, 1'b1, 1'b1, 3'd0, 1, 1, 32'h8001_1234, 1'b1, -1);
    do_txn(7'b1010000, 32'h0000_2002, 32'h0, 32'h0, 1'b1, 1'b1, 3'd0, 0, 1, 32'h8001_1234, 1'b1, -1);
    do_txn(7'b1010000, 32'h0000_2000, 32'h0, 32'h0, 1'b1, 1'b1, 3'd0, 0, 1, 32'h1234_5678, 1'b1, -1);
    do_txn(7'b1010000, 32'h0000_2000, 32'h0, 32'h0, 1'b1, 1'b1, 3'd0, 0, 3, 32'hDEAD_BEEF, 1'b1, 1);

    // Reset asserted while a write is held in REQ.
    @(negedge clk);
    mem_l1d_bus_in = 7'b1110000; mem_addr_in = 32'h0000_0100; mem_w_data_in = 32'hCAFE_F00D;
    mem_alu_result_in = 32'h5555_AAAA; mem_we_reg_file_in = 1'b1; mem_mux_alu_mem_in = 1'b0;
    mem_enb = 1'b1; mem_kill = 1'b0; l1d_req_ack = 1'b0; l1d_resp_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_l1d_bus_in = 7'b0;
    #1;
    chk("req_hold_val", 32'(l1d_req_val), 32'h1);
    chk("req_hold_addr", l1d_req_addr, 32'h0000_0100);
    rst = 1'b1;
    #1;
    chk("rst_mid_req_val", 32'(l1d_req_val), 32'h0);
    chk("rst_mid_stall", 32'(mem_stall), 32'h0);
    chk("rst_mid_addr", l1d_req_addr, 32'h0);
    chk("rst_mid_wb_data", mem_wb_data_out_reg, 32'h0);
    chk("rst_mid_wb_we", 32'(mem_we_reg_file_out_reg), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_data = 32'h0; exp_we = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_req_val", 32'(l1d_req_val), 32'h0);
    chk("post_rst_stall", 32'(mem_stall), 32'h0);

    // Randomized transactions, back to back.
    for (int i = 0; i < 400; i++) begin
      bus    = {1'($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), 3'b000};
      ack_d  = $urandom_range(0, 3);
      resp_d = $urandom_range(1, 3);
      kk     = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      do_txn(bus, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
             3'($urandom_range(0, 7)), ack_d, resp_d, $urandom,
             1'($urandom_range(0, 5) != 0), kk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_mem_s.md
# core_mem_s

Memory stage of the Selen core pipeline, sitting between execute and writeback. It consumes the registered request from execute (L1D request bus, address, store data, write-back sign-extension op) and drives the L1D data-port request/response handshake. It stalls the pipeline until the access completes, then aligns and sign/zero-extends load data. Its output registers feed the writeback stage.

## Interface
- No parameters.
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- mem_enb  input  1  stage enable; output registers capture only when high
- mem_kill  input  1  flush stage output registers to bubble
- mem_l1d_bus_in  input  7  [6] request valid, [5] write, [4:3] size (00 byte, 01 half, 10 word, 11 illegal), [2:0] zero; all-zero = NOT_REQ
- mem_addr_in  input  32  access address
- mem_w_data_in  input  32  store data, right-aligned
- mem_alu_result_in  input  32  ALU result
- mem_mux_alu_mem_in  input  1  1 = write back load data, 0 = ALU result
- mem_we_reg_file_in  input  1  register-file write enable
- mem_wb_sx_op_in  input  3  000 WB_SX_BP (pass word), 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; others = pass word
- l1d_req_val  output  1  request valid
- l1d_req_we  output  1  write request
- l1d_req_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- l1d_req_wdata  output  32  lane-replicated store data
- l1d_req_be  output  4  byte enables
- l1d_req_ack  input  1  L1D accepted request this cycle
- l1d_resp_val  input  1  read data valid
- l1d_resp_data  input  32  read word
- mem_stall  output  1  hold upstream stages this cycle
- mem_misalign  output  1  one-cycle pulse: misaligned access dropped
- mem_wb_data_out_reg  output  32  write-back data
- mem_we_reg_file_out_reg  output  1  write-back enable

## Operation
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE: request valid and aligned -> drive l1d_req_val combinationally; ack same cycle -> write: done; read: go WAIT_RESP. No ack -> go REQ.
- REQ: hold l1d_req_val and all request fields stable until ack; ack -> write: IDLE; read: WAIT_RESP.
- WAIT_RESP: l1d_resp_val -> capture data, go IDLE. Response never valid in the ack cycle.
- Request fields are latched at acceptance into REQ; the inputs may change while stalled.
- mem_stall = transaction active and not completing this cycle (write: ack; read: resp_val).
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; size 11 illegal. On violation: no request, mem_misalign pulses, we forced 0 in output register, no stall.
- Byte enables: byte -> 1<<addr[1:0], wdata = {4{w_data[7:0]}}; half -> addr[1] ? 1100 : 0011, wdata = {2{w_data[15:0]}}; word -> 1111.
- Load extract: byte lane addr[1:0], half lane addr[1]; extend per mem_wb_sx_op_in.
- Output capture when mem_enb & !mem_stall: data = mux_alu_mem ? extended load : ALU result.
- mem_kill: outputs -> data 0, we 0; priority over enb. Kill does not abort an in-flight L1D transaction; it completes, result discarded.

## Timing
- Reset: state IDLE, l1d_req_val 0, l1d_req_we 0, l1d_req_addr 0, l1d_req_wdata 0, l1d_req_be 0, mem_stall 0, mem_misalign 0, mem_wb_data_out_reg 0, mem_we_reg_file_out_reg 0.
- Reset mid-transaction: immediately IDLE, request dropped; L1D must tolerate.
- Non-memory op: 0 stall cycles, output in next edge.
- Write with same-cycle ack: 0 stall cycles. Each cycle of ack delay adds one stall cycle.
- Read: minimum 1 stall cycle (ack cycle 0, resp cycle 1); output register updated at the resp edge.
- Back-to-back requests: a new request may be issued in the cycle after completion, from IDLE.

## Test plan
- Reset during REQ with addr 0x100 -> all outputs 0, state IDLE, req_val low on reset assert.
- SB addr 0x1003 data 0x000000A5, ack in cycle 2 -> be 1000, wdata 0xA5A5A5A5, req stable for 2 cycles, mem_stall high exactly 2 cycles.
- LB signed addr 0x2001, resp 0x0000_80_00 (byte1 = 0x80), ack cycle 0, resp cycle 3 -> wb data 0xFFFFFF80, stall 3 cycles; LBU same -> 0x00000080.
- LH signed addr 0x2002, resp 0x8001_1234 -> 0xFFFF8001; LW addr 0x2000 -> 0x80011234.
- LW addr 0x2002 -> no l1d_req_val, mem_misalign one-cycle pulse, we_out 0, no stall.
- mem_kill during WAIT_RESP of a load -> resp still consumed, stall released on resp, outputs 0 / we 0.
